// File: rtl/store_narrow_unit.sv
// store_narrow_unit
// Narrows 32-bit register store data into a word-aligned, big-endian,
// lane-replicated memory write with byte enables. A small FIFO decouples
// the MEM stage from data-memory back-pressure.
// Optional feature macro: STORE_ALIGN_CHECK_EN (adds AlignErr / ErrAddr,
// misaligned requests are accepted but dropped).
module store_narrow_unit #(
    parameter int DEPTH = 2
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [31:0]              InAddr,
    input  logic [31:0]              InData,
    input  logic [1:0]               InSize,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [31:0]              OutAddr,
    output logic [31:0]              OutData,
    output logic [3:0]               OutByteEn,
    output logic [$clog2(DEPTH):0]   Count
`ifdef STORE_ALIGN_CHECK_EN
    ,
    output logic                     AlignErr,
    output logic [31:0]              ErrAddr
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Per-entry storage: formatted data, byte enables, word address
    logic [31:0]   data_mem_r [DEPTH];
    logic [3:0]    be_mem_r   [DEPTH];
    logic [29:0]   addr_mem_r [DEPTH];

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          in_ready_r;

    logic          push_s;
    logic          pop_s;
    logic          enq_s;
    logic [CW-1:0] count_next_s;
    logic [35:0]   fmt_s;

    // Big-endian lane formatting: {byte_enables, replicated_data}
    function automatic logic [35:0] format_lanes(input logic [1:0]  size,
                                                 input logic [1:0]  k,
                                                 input logic [31:0] data);
        logic [35:0] res;
        case (size)
            2'b00:   res = {4'b1000 >> k, {4{data[7:0]}}};
            2'b01:   res = {(k[1] ? 4'b0011 : 4'b1100), {2{data[15:0]}}};
            2'b10:   res = {4'b1111, data};
            default: res = {4'b1111, data};
        endcase
        return res;
    endfunction

`ifdef STORE_ALIGN_CHECK_EN
    // Natural-alignment rule; the reserved size is always an error
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] k);
        logic res;
        case (size)
            2'b00:   res = 1'b0;
            2'b01:   res = k[0];
            2'b10:   res = (k != 2'b00);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    logic        misalign_s;
    logic        align_err_r;
    logic [31:0] err_addr_r;

    assign misalign_s = is_misaligned(InSize, InAddr[1:0]);
    assign AlignErr   = align_err_r;
    assign ErrAddr    = err_addr_r;

    // One-cycle error pulse and sticky address of the last misaligned store
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            align_err_r <= 1'b0;
            err_addr_r  <= 32'h0000_0000;
        end else begin
            align_err_r <= push_s && misalign_s;
            if (push_s && misalign_s) begin
                err_addr_r <= InAddr;
            end
        end
    end
`endif

    assign push_s = InValid && in_ready_r;
    assign pop_s  = (count_r != {CW{1'b0}}) && OutReady;
    assign fmt_s  = format_lanes(InSize, InAddr[1:0], InData);

    // Decide whether an accepted request actually occupies an entry
    always_comb begin
        enq_s = push_s;
`ifdef STORE_ALIGN_CHECK_EN
        if (misalign_s) begin
            enq_s = 1'b0;
        end else begin
            enq_s = push_s;
        end
`endif
    end

    // Occupancy after this edge; push+pop together leaves it unchanged
    always_comb begin
        count_next_s = count_r;
        case ({enq_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and registered ready
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                be_mem_r[i]   <= 4'b0000;
                addr_mem_r[i] <= 30'h0000_0000;
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (enq_s) begin
                data_mem_r[wr_ptr_r] <= fmt_s[31:0];
                be_mem_r[wr_ptr_r]   <= fmt_s[35:32];
                addr_mem_r[wr_ptr_r] <= InAddr[31:2];
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s != DEPTH_C);
        end
    end

    assign InReady   = in_ready_r;
    assign OutValid  = (count_r != {CW{1'b0}});
    assign OutAddr   = {addr_mem_r[rd_ptr_r], 2'b00};
    assign OutData   = data_mem_r[rd_ptr_r];
    assign OutByteEn = be_mem_r[rd_ptr_r];
    assign Count     = count_r;

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Narrowing counterpart to the immediate/load sign-extender in the MIPS datapath: takes 32-bit register store data plus a size code and drives a 32-bit word-aligned memory write port with lane-replicated data and byte enables.
- Lane mapping is big-endian.
- Sits between the MEM stage and the data memory, with a small FIFO so that memory back-pressure does not stall MEM immediately.

Parameters:
- DEPTH, 2, number of buffered store entries; power of 2, minimum 2.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- InValid  input  1  store request valid
- InReady  output  1  unit can accept a request this cycle
- InAddr  input  32  byte address of the store
- InData  input  32  register data; only low byte or halfword used for sb/sh
- InSize  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- OutValid  output  1  memory write valid
- OutReady  input  1  memory accepts the write
- OutAddr  output  32  word address, {InAddr[31:2],2'b00}
- OutData  output  32  lane-replicated write data
- OutByteEn  output  4  bit3 = OutData[31:24] ... bit0 = OutData[7:0]
- Count  output  $clog2(DEPTH)+1  entries currently held

Behaviour:
- Reset (async assert, sync release): pointers and Count = 0; OutValid = 0; InReady = 1; OutAddr, OutData and OutByteEn = 0 (storage cleared). Reset mid-operation discards all entries.
- A push occurs on a Clk edge when InValid && InReady.
- A pop occurs on a Clk edge when OutValid && OutReady.
- InReady = (Count != DEPTH). It is registered and does not depend on OutReady, so a full unit refuses a push even while popping.
- OutValid = (Count != 0). OutAddr, OutData and OutByteEn always reflect the head entry.
- Latency: a request pushed into an empty unit at edge N appears on the outputs right after edge N. Head entries move to the outputs one per pop.
- Simultaneous push and pop: Count unchanged; both pointers advance.
- Output stability: while OutValid && !OutReady, all Out* signals hold.
- Pointers wrap modulo DEPTH.
- Lane formatting is done at push time and stored per entry (k = InAddr[1:0]):
  - Byte: OutData = {4{InData[7:0]}}, OutByteEn = 4'b1000 >> k.
  - Halfword: OutData = {2{InData[15:0]}}, OutByteEn = InAddr[1] ? 4'b0011 : 4'b1100.
  - Word: OutData = InData, OutByteEn = 4'b1111.
  - Reserved (11): handled as word when the optional feature is off.
- InValid with InReady = 0: no effect. The requester must hold the request.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN
- Defined: adds ports AlignErr (output, 1) and ErrAddr (output, 32), both reset to 0.
  - A request is misaligned when it is a halfword with InAddr[0] = 1, a word with InAddr[1:0] != 0, or uses size 11.
  - A misaligned request is accepted (handshake completes) but not enqueued; Count is unchanged.
  - AlignErr pulses high for exactly one cycle after the accepting edge.
  - ErrAddr captures InAddr and holds until the next error.
- Undefined: no extra ports. Halfword uses InAddr[1] only, word ignores InAddr[1:0], and size 11 is treated as word.

Test Plan:
1. Reset while holding 2 entries (Rst_n low mid-cycle) -> immediately OutValid = 0, Count = 0, InReady = 1, OutData = 0.
2. Byte store, InAddr = 0x1000_0002, InData = 0xDEAD_BEA5, OutReady = 1 -> next cycle OutAddr = 0x1000_0000, OutData = 0xA5A5_A5A5, OutByteEn = 0010; popped on the following edge.
3. Halfword store to 0x2000_0006, InData = 0x0000_1234 -> OutData = 0x1234_1234, OutByteEn = 0011. Same data to 0x2000_0004 -> OutByteEn = 1100.
4. OutReady = 0, push 3 word stores (A, B, C) -> Count reaches 2 and InReady = 0; C held by the requester. Release OutReady -> A, B, C emerge in order, each with OutByteEn = 1111, and Count returns to 0.
5. Count = 1 with push and pop on the same edge -> Count stays 1 and the output advances to the new entry. Run 8 push/pop pairs to cover pointer wrap.
6. With STORE_ALIGN_CHECK_EN: word store to 0x0000_0102 -> accepted; AlignErr = 1 for one cycle; ErrAddr = 0x0000_0102; Count stays 0; OutValid stays 0.
